// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding and the stream section codes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_SECT,
    S_CNT_HI,
    S_CNT_LO,
    S_PAYLOAD,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] SEC_TEXT = 8'h01;
  localparam logic [7:0] SEC_DATA = 8'h02;
  localparam logic [7:0] SEC_END  = 8'hFF;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles four MSB-first stream bytes into a 32-bit word.
// word/word_valid are combinational on the 4th byte so the caller can register the write.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
    end else if (byte_valid) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      shift_q    <= {shift_q[15:0], byte_in};
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_valid && (byte_idx_q == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that writes text/data words for the core and holds it idle
// until the end-of-image marker arrives.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_e      state_q;
  logic        sel_q;
  logic [31:0] base_q;
  logic [7:0]  cnt_hi_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;

  logic        accept;
  logic [15:0] count_next;
  logic        packer_clear;
  logic        packer_valid;
  logic [31:0] word;
  logic        word_valid;

  assign accept       = in_valid && in_ready;
  assign count_next   = {cnt_hi_q, in_data};
  assign packer_clear = accept && (state_q == S_CNT_LO);
  assign packer_valid = accept && (state_q == S_PAYLOAD);

  byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .byte_valid (packer_valid),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_SECT;
      sel_q        <= 1'b0;
      base_q       <= 32'd0;
      cnt_hi_q     <= 8'd0;
      count_q      <= 16'd0;
      word_idx_q   <= 16'd0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_sel      <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      // Terminal states keep in_ready low; transitions into them override below.
      if (state_q != S_DONE && state_q != S_ERR) begin
        in_ready <= 1'b1;
      end
      if (accept) begin
        case (state_q)
          S_SECT: begin
            case (in_data)
              SEC_TEXT: begin
                sel_q   <= 1'b0;
                base_q  <= TEXT_BASE;
                state_q <= S_CNT_HI;
              end
              SEC_DATA: begin
                sel_q   <= 1'b1;
                base_q  <= DATA_BASE;
                state_q <= S_CNT_HI;
              end
              SEC_END: begin
                state_q  <= S_DONE;
                done     <= 1'b1;
                cpu_run  <= 1'b1;
                in_ready <= 1'b0;
              end
              default: begin
                state_q  <= S_ERR;
                error    <= 1'b1;
                in_ready <= 1'b0;
              end
            endcase
          end
          S_CNT_HI: begin
            cnt_hi_q <= in_data;
            state_q  <= S_CNT_LO;
          end
          S_CNT_LO: begin
            if (count_next == 16'd0) begin
              state_q <= S_SECT;
            end else if (32'(count_next) > MAX_WORDS) begin
              state_q  <= S_ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              count_q    <= count_next;
              word_idx_q <= 16'd0;
              state_q    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (word_valid) begin
              mem_we    <= 1'b1;
              mem_sel   <= sel_q;
              mem_addr  <= base_q + {14'd0, word_idx_q, 2'b00};
              mem_wdata <= word;
              if (words_loaded != 16'hFFFF) begin
                words_loaded <= words_loaded + 16'd1;
              end
              if (word_idx_q == count_q - 16'd1) begin
                state_q <= S_SECT;
              end else begin
                word_idx_q <= word_idx_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames from the bring-up scenarios plus random
// multi-section images compared against a frame-parsing reference model.
module tb_program_loader;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int          MAXW      = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, mem_sel, cpu_run, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  program_loader #(
    .TEXT_BASE (TEXT_BASE),
    .DATA_BASE (DATA_BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  // Write record: {sel, addr, data}
  logic [64:0] got[$];
  logic [64:0] exp[$];
  logic [7:0]  stream[$];
  bit          exp_done, exp_err;

  always @(negedge clk) if (mem_we === 1'b1) got.push_back({mem_sel, mem_addr, mem_wdata});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got.delete();
  endtask

  // Presents one byte after `gap` idle cycles; returns once it has been accepted.
  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drive(input int mingap, input int maxgap);
    bit ok;
    for (int i = 0; i < stream.size(); i++) begin
      send(stream[i], int'($urandom_range(maxgap, mingap)), ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL accept byte %0d: in_ready stayed 0, required 1", i);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference: walk the frames and list every word the image should produce.
  task automatic model();
    int i, n;
    logic sel;
    logic [31:0] base;
    exp.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] == 8'hFF) begin exp_done = 1'b1; break; end
      if (stream[i] != 8'h01 && stream[i] != 8'h02) begin exp_err = 1'b1; break; end
      sel = (stream[i] == 8'h02);
      base = sel ? DATA_BASE : TEXT_BASE;
      if (i + 2 >= stream.size()) break;
      n = int'(stream[i+1]) * 256 + int'(stream[i+2]);
      i += 3;
      if (n > MAXW) begin exp_err = 1'b1; break; end
      for (int w = 0; w < n && i + 4 * w + 3 < stream.size(); w++)
        exp.push_back({sel, base + 32'(4 * w), stream[i+4*w], stream[i+4*w+1],
                       stream[i+4*w+2], stream[i+4*w+3]});
      i += 4 * n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_sel, cpu_run, done, error, words_loaded, mem_addr, mem_wdata}
        !== 86'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b run=%b done=%b err=%b words=%0d, required all 0",
               in_ready, mem_we, cpu_run, done, error, words_loaded);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic(input string name, input int gap);
    do_reset();
    stream = '{8'h01, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h00, 8'h00, 8'h00, 8'h0C, 8'hFF};
    drive(gap, gap);
    exp = '{{1'b0, 32'h0040_0000, 32'h2008_0005}, {1'b0, 32'h0040_0004, 32'h0000_000C}};
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got %h, required %h", name, i,
                 (i < got.size()) ? got[i] : 65'bx, exp[i]);
      end
    end
    checks++;
    if ({done, cpu_run, error, in_ready, words_loaded} !== {4'b1100, 16'd2}) begin
      errors++;
      $display("FAIL %s_status: done=%b run=%b err=%b rdy=%b words=%0d, required 1 1 0 0 2",
               name, done, cpu_run, error, in_ready, words_loaded);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    stream = '{8'h02, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'hFF};
    drive(1, 1);
    checks++;
    if (got.size() != 1 || got[0] !== {1'b1, 32'h1001_0000, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL toggle_write: got %0d writes first %h, required 1 write %h", got.size(),
               (got.size() > 0) ? got[0] : 65'bx, {1'b1, 32'h1001_0000, 32'hDEAD_BEEF});
    end
    checks++;
    if ({done, cpu_run, words_loaded} !== {2'b11, 16'd1}) begin
      errors++;
      $display("FAIL toggle_status: done=%b run=%b words=%0d, required 1 1 1",
               done, cpu_run, words_loaded);
    end
  endtask

  task automatic test_bad_section();
    bit ok;
    do_reset();
    send(8'h07, 0, ok);
    checks++;
    if ({ok, error, in_ready, cpu_run, done} !== 5'b11000) begin
      errors++;
      $display("FAIL bad_sect_status: ok=%b err=%b rdy=%b run=%b done=%b, required 1 1 0 0 0",
               ok, error, in_ready, cpu_run, done);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = (i == 0) ? 8'h01 : 8'(i * 17);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 0 || words_loaded !== 16'd0 || error !== 1'b1 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL bad_sect_ignore: writes=%0d words=%0d err=%b run=%b, required 0 0 1 0",
               got.size(), words_loaded, error, cpu_run);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    stream = '{8'h01, 8'h04, 8'h01};
    drive(0, 0);
    checks++;
    if ({error, in_ready, cpu_run} !== 3'b100 || got.size() != 0) begin
      errors++;
      $display("FAIL overflow: err=%b rdy=%b run=%b writes=%0d, required 1 0 0 0",
               error, in_ready, cpu_run, got.size());
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    stream = '{8'h01, 8'h00, 8'h01, 8'h99, 8'h88};
    drive(0, 0);
    do_reset();
    stream = '{8'h01, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    drive(0, 0);
    checks++;
    if (got.size() != 1 || got[0] !== {1'b0, 32'h0040_0000, 32'h1122_3344}) begin
      errors++;
      $display("FAIL mid_reset_write: got %0d writes first %h, required 1 write %h", got.size(),
               (got.size() > 0) ? got[0] : 65'bx, {1'b0, 32'h0040_0000, 32'h1122_3344});
    end
    checks++;
    if (words_loaded !== 16'd1 || done !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_status: words=%0d done=%b, required 1 1", words_loaded, done);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    stream = '{8'h01, 8'h00, 8'h01, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
               8'h01, 8'h00, 8'h01, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hFF};
    drive(0, 0);
    exp = '{{1'b0, 32'h0040_0000, 32'hAAAA_AAAA}, {1'b0, 32'h0040_0000, 32'hBBBB_BBBB}};
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL overwrite_count: got %0d writes, required 2", got.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL overwrite_write%0d: got %h, required %h", i,
                 (i < got.size()) ? got[i] : 65'bx, exp[i]);
      end
    end
    checks++;
    if (words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL overwrite_words: got %0d, required 2", words_loaded);
    end
  endtask

  // Random images, plus one full-depth section at the MAX_WORDS boundary.
  task automatic test_random(input int iters, input bit full_depth);
    int n, nsec, bad;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      stream.delete();
      nsec = full_depth ? 1 : int'($urandom_range(4, 1));
      for (int s = 0; s < nsec; s++) begin
        n = full_depth ? MAXW : int'($urandom_range(4, 0));
        stream.push_back($urandom_range(1, 0) ? 8'h02 : 8'h01);
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int b = 0; b < 4 * n; b++) stream.push_back(8'($urandom));
      end
      bad = (!full_depth && $urandom_range(4, 0) == 0) ? 1 : 0;
      stream.push_back(bad ? 8'($urandom_range(8'hFE, 8'h03)) : 8'hFF);
      model();
      drive(0, full_depth ? 0 : 2);
      checks++;
      if (got.size() != exp.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d writes, required %0d", it, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (i >= got.size() || got[i] !== exp[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h, required %h", it, i,
                   (i < got.size()) ? got[i] : 65'bx, exp[i]);
          break;
        end
      end
      checks++;
      if ({done, cpu_run, error, in_ready} !== {exp_done, exp_done, exp_err, 1'b0} ||
          words_loaded !== 16'(exp.size())) begin
        errors++;
        $display("FAIL rand%0d_status: done=%b run=%b err=%b rdy=%b words=%0d, required %b %b %b 0 %0d",
                 it, done, cpu_run, error, in_ready, words_loaded, exp_done, exp_done, exp_err,
                 exp.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic", 0);
    test_toggle();
    test_bad_section();
    test_overflow();
    test_reset_mid_load();
    test_overwrite();
    test_random(20, 1'b0);
    test_random(1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
